// File: rtl/immgen_stage_if.sv
// Decode-stage handshake bundle for immgen_stage.
// Ports:
//   in_valid/in_ready/in_instr/in_pc  - instruction + PC input channel
//   out_valid/out_ready/out_*         - registered decode result channel
// Modports: slave = stage view, master = producer/consumer view.
interface immgen_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_target,
           out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_target,
           out_fmt, out_illegal
  );
endinterface

// File: rtl/immgen_stage.sv
// Registered RV immediate-generation stage with a 2-entry skid buffer.
// Decodes the instruction format, builds the sign-extended immediate and
// pc + imm on the input side, then holds results in OUT/SKID registers.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset (zeroes data, empties stage)
//   flush - synchronous; drops held entries and the current input
//   bus   - immgen_stage_if.slave handshake bundle
// XLEN must be 32 or 64.
module immgen_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  immgen_stage_if.slave  bus
);

  localparam int unsigned IW = 32;
  localparam int unsigned FW = 3;

  localparam logic [FW-1:0] FMT_R = 3'd0;
  localparam logic [FW-1:0] FMT_I = 3'd1;
  localparam logic [FW-1:0] FMT_S = 3'd2;
  localparam logic [FW-1:0] FMT_B = 3'd3;
  localparam logic [FW-1:0] FMT_U = 3'd4;
  localparam logic [FW-1:0] FMT_J = 3'd5;
  localparam logic [FW-1:0] FMT_X = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [IW-1:0]   instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [FW-1:0]   fmt;
    logic            illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t dec_c;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   accept_c;
  logic   drain_c;

  logic [IW-1:0]        ins;
  logic signed [IW-1:0] imm32_c;

  assign ins = bus.in_instr;

  // Format decode and immediate assembly; every format fits in 32 bits and
  // is then sign-extended to XLEN by a signed width cast.
  always_comb begin : decode
    imm32_c     = '0;
    dec_c       = '0;
    dec_c.instr = ins;
    dec_c.pc    = bus.in_pc;
    case (ins[6:0])
      7'b0000011, 7'b0001111, 7'b0010011,
      7'b0011011, 7'b1100111, 7'b1110011: begin
        dec_c.fmt = FMT_I;
        imm32_c   = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        dec_c.fmt = FMT_S;
        imm32_c   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec_c.fmt = FMT_B;
        imm32_c   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_c.fmt = FMT_U;
        imm32_c   = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_c.fmt = FMT_J;
        imm32_c   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: begin
        dec_c.fmt = FMT_R;
      end
      default: begin
        dec_c.fmt     = FMT_X;
        dec_c.illegal = 1'b1;
      end
    endcase
    dec_c.imm    = XLEN'(imm32_c);
    dec_c.target = bus.in_pc + dec_c.imm;
  end

  // Occupancy FSM: OUT always holds the oldest entry, SKID the younger one.
  always_comb begin : next_state
    state_d  = state_q;
    out_d    = out_q;
    skid_d   = skid_q;
    accept_c = bus.in_valid & in_ready_q;
    drain_c  = out_valid_q & bus.out_ready;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            out_d   = dec_c;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept_c && drain_c) begin
            out_d = dec_c;
          end else if (drain_c) begin
            state_d = EMPTY;
          end else if (accept_c) begin
            skid_d  = dec_c;
            state_d = TWO;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (drain_c) begin
            out_d   = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers; handshake flags derive from the next state so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk) begin : regs
    if (reset) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_target  = out_q.target;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: drives an XLEN=64 and an XLEN=32 instance with the
// same stimulus and checks both against a queue-based reference model.
module tb_immgen_stage;

  logic clk;
  logic reset;
  logic flush;

  immgen_stage_if #(.XLEN(64)) b64 ();
  immgen_stage_if #(.XLEN(32)) b32 ();

  immgen_stage #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(b64));
  immgen_stage #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  localparam logic [6:0] OPS [12] = '{
    7'b0000011, 7'b0001111, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011,
    7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011
  };

  exp_t q[$];
  logic zero_out;
  int   total;
  int   bad;

  // Reference: pick bit fields with shifts/masks, then sign-extend arithmetically.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
    exp_t        e;
    longint      x;
    longint      v;
    int          n;
    logic [6:0]  op;
    x  = longint'({32'b0, ins});
    op = ins[6:0];
    v  = 0;
    n  = 1;
    e  = '0;
    e.instr = ins;
    e.pc    = pc;
    case (op) inside
      7'b0000011, 7'b0001111, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        e.fmt = 3'd1; v = x >> 20; n = 12;
      end
      7'b0100011: begin
        e.fmt = 3'd2; v = ((x >> 25) << 5) | ((x >> 7) & 31); n = 12;
      end
      7'b1100011: begin
        e.fmt = 3'd3;
        v = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
            (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
        n = 13;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4; v = (x >> 12) << 12; n = 32;
      end
      7'b1101111: begin
        e.fmt = 3'd5;
        v = (((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
            (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
        n = 21;
      end
      7'b0110011, 7'b0111011: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    if (((v >> (n - 1)) & 1) != 0) v = v - (longint'(1) << n);
    e.imm = 64'(v);
    e.tgt = pc + e.imm;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r[6:0] = 7'($urandom);
    else r[6:0] = OPS[$urandom_range(0, 11)];
    return r;
  endfunction

  function automatic exp_t head();
    exp_t h;
    h = '0;
    if (q.size() > 0) h = q[0];
    return h;
  endfunction

  function automatic logic [229:0] exp64();
    exp_t h;
    h = head();
    return {q.size() > 0, q.size() < 2, h.instr, h.pc, h.imm, h.tgt, h.fmt, h.ill};
  endfunction

  function automatic logic [229:0] msk64();
    if (q.size() > 0 || zero_out) return '1;
    return {2'b11, 228'b0};
  endfunction

  function automatic logic [229:0] obs64();
    return {b64.out_valid, b64.in_ready, b64.out_instr, b64.out_pc, b64.out_imm,
            b64.out_target, b64.out_fmt, b64.out_illegal};
  endfunction

  function automatic logic [133:0] exp32();
    exp_t h;
    h = head();
    return {q.size() > 0, q.size() < 2, h.instr, h.pc[31:0], h.imm[31:0],
            h.tgt[31:0], h.fmt, h.ill};
  endfunction

  function automatic logic [133:0] msk32();
    if (q.size() > 0 || zero_out) return '1;
    return {2'b11, 132'b0};
  endfunction

  function automatic logic [133:0] obs32();
    return {b32.out_valid, b32.in_ready, b32.out_instr, b32.out_pc, b32.out_imm,
            b32.out_target, b32.out_fmt, b32.out_illegal};
  endfunction

  // One clock: drive inputs at negedge, advance the model at posedge, settle.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl, input logic rst,
                      output logic acc);
    logic drn;
    exp_t e;
    @(negedge clk);
    reset = rst;
    flush = fl;
    b64.in_valid = v;    b32.in_valid = v;
    b64.in_instr = ins;  b32.in_instr = ins;
    b64.in_pc    = pc;   b32.in_pc    = pc[31:0];
    b64.out_ready = ordy; b32.out_ready = ordy;
    acc = v && (q.size() < 2) && !fl && !rst;
    drn = (q.size() > 0) && ordy;
    e   = model(ins, pc);
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
      if (rst) zero_out = 1'b1;
    end else begin
      if (drn) q.delete(0);
      if (acc) begin
        q.push_back(e);
        zero_out = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, rnd_instr(), {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b1, acc);
      total++;
      if (obs64() !== {1'b0, 1'b1, 228'b0}) begin
        bad++; $display("FAIL reset64 got=%h want=%h", obs64(), {1'b0, 1'b1, 228'b0});
      end
      total++;
      if (obs32() !== {1'b0, 1'b1, 132'b0}) begin
        bad++; $display("FAIL reset32 got=%h want=%h", obs32(), {1'b0, 1'b1, 132'b0});
      end
    end
  endtask

  task automatic test_isb();
    logic [31:0] ins_t [3] = '{32'hFFF02003, 32'hFE102F23, 32'hF00007E3};
    logic [31:0] imm_t [3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFF0E};
    logic [2:0]  fmt_t [3] = '{3'd1, 3'd2, 3'd3};
    logic acc;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ins_t[i], 64'h100, 1'b1, 1'b0, 1'b0, acc);
      total++;
      if (b32.out_valid !== 1'b1 || b32.out_imm !== imm_t[i] || b32.out_fmt !== fmt_t[i]) begin
        bad++;
        $display("FAIL isb%0d got v=%b imm=%h fmt=%0d want v=1 imm=%h fmt=%0d",
                 i, b32.out_valid, b32.out_imm, b32.out_fmt, imm_t[i], fmt_t[i]);
      end
      total++;
      if ((obs32() & msk32()) !== (exp32() & msk32())) begin
        bad++; $display("FAIL isb_model32 got=%h want=%h", obs32() & msk32(), exp32() & msk32());
      end
    end
    total++;
    if (b32.out_target !== 32'h0000000E) begin
      bad++; $display("FAIL isb_btarget got=%h want=0000000e", b32.out_target);
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
    total++;
    if (b32.out_valid !== 1'b0) begin
      bad++; $display("FAIL isb_drain got=%b want=0", b32.out_valid);
    end
  endtask

  task automatic test_uj();
    logic acc;
    step(1'b1, 32'h800000B7, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, acc);
    total++;
    if (b64.out_imm !== 64'hFFFFFFFF80000000 || b64.out_fmt !== 3'd4) begin
      bad++; $display("FAIL lui64 got imm=%h fmt=%0d want imm=ffffffff80000000 fmt=4",
                      b64.out_imm, b64.out_fmt);
    end
    step(1'b1, 32'h0000006F, 64'h1000, 1'b1, 1'b0, 1'b0, acc);
    total++;
    if (b64.out_imm !== 64'h0 || b64.out_target !== 64'h1000 || b64.out_fmt !== 3'd5) begin
      bad++; $display("FAIL jal64 got imm=%h tgt=%h fmt=%0d want imm=0 tgt=1000 fmt=5",
                      b64.out_imm, b64.out_target, b64.out_fmt);
    end
    total++;
    if ((obs64() & msk64()) !== (exp64() & msk64())) begin
      bad++; $display("FAIL uj_model64 got=%h want=%h", obs64() & msk64(), exp64() & msk64());
    end
  endtask

  task automatic test_illegal_r();
    logic acc;
    step(1'b1, 32'h00000000, 64'h2000, 1'b1, 1'b0, 1'b0, acc);
    total++;
    if (b64.out_illegal !== 1'b1 || b64.out_fmt !== 3'd7 || b64.out_imm !== 64'h0) begin
      bad++; $display("FAIL illegal got ill=%b fmt=%0d imm=%h want ill=1 fmt=7 imm=0",
                      b64.out_illegal, b64.out_fmt, b64.out_imm);
    end
    step(1'b1, 32'h00B50533, 64'h2004, 1'b1, 1'b0, 1'b0, acc);
    total++;
    if (b32.out_illegal !== 1'b0 || b32.out_fmt !== 3'd0 || b32.out_imm !== 32'h0) begin
      bad++; $display("FAIL rtype got ill=%b fmt=%0d imm=%h want ill=0 fmt=0 imm=0",
                      b32.out_illegal, b32.out_fmt, b32.out_imm);
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic test_backpressure();
    logic [31:0] pend[$];
    logic [31:0] sent[$];
    logic [31:0] got[$];
    logic acc;
    logic ordy;
    for (int i = 0; i < 4; i++) begin
      pend.push_back(rnd_instr());
      sent.push_back(pend[i]);
    end
    for (int k = 0; k < 24 && (pend.size() > 0 || q.size() > 0); k++) begin
      ordy = !(k >= 1 && k <= 3);
      if (b64.out_valid && ordy) got.push_back(b64.out_instr);
      if (pend.size() > 0) step(1'b1, pend[0], {$urandom, $urandom}, ordy, 1'b0, 1'b0, acc);
      else step(1'b0, 32'h0, 64'h0, ordy, 1'b0, 1'b0, acc);
      if (acc) pend.delete(0);
      if (k == 2 || k == 3) begin
        total++;
        if (b64.in_ready !== 1'b0 || b32.in_ready !== 1'b0) begin
          bad++; $display("FAIL bp_full_ready k=%0d got=%b%b want=00", k, b64.in_ready, b32.in_ready);
        end
      end
      total++;
      if ((obs64() & msk64()) !== (exp64() & msk64())) begin
        bad++; $display("FAIL bp_model64 k=%0d got=%h want=%h", k, obs64() & msk64(), exp64() & msk64());
      end
      total++;
      if ((obs32() & msk32()) !== (exp32() & msk32())) begin
        bad++; $display("FAIL bp_model32 k=%0d got=%h want=%h", k, obs32() & msk32(), exp32() & msk32());
      end
    end
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d want=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== sent[i]) begin
          bad++; $display("FAIL bp_order%0d got=%h want=%h", i, got[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic acc;
    logic [31:0] dropped;
    step(1'b1, rnd_instr(), {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, rnd_instr(), {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, acc);
    total++;
    if (q.size() != 2 || b64.in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_setup got held=%0d ready=%b want held=2 ready=0", q.size(), b64.in_ready);
    end
    dropped = 32'h12345013;
    step(1'b1, dropped, 64'h40, 1'b0, 1'b1, 1'b0, acc);
    total++;
    if (b64.out_valid !== 1'b0 || b64.in_ready !== 1'b1 ||
        b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_state got v=%b%b r=%b%b want v=00 r=11",
                      b64.out_valid, b32.out_valid, b64.in_ready, b32.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
      total++;
      if (b64.out_valid !== 1'b0 || b32.out_valid !== 1'b0) begin
        bad++; $display("FAIL flush_dropped k=%0d got v=%b%b instr=%h want v=00",
                        k, b64.out_valid, b32.out_valid, b64.out_instr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    step(1'b1, rnd_instr(), {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, acc);
    total++;
    if (b64.out_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_setup got v=%b want v=1", b64.out_valid);
    end
    step(1'b1, rnd_instr(), {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, acc);
    total++;
    if (obs64() !== {1'b0, 1'b1, 228'b0}) begin
      bad++; $display("FAIL rmid64 got=%h want=%h", obs64(), {1'b0, 1'b1, 228'b0});
    end
    total++;
    if (obs32() !== {1'b0, 1'b1, 132'b0}) begin
      bad++; $display("FAIL rmid32 got=%h want=%h", obs32(), {1'b0, 1'b1, 132'b0});
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, rnd_instr(), {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 149) == 0, acc);
      total++;
      if ((obs64() & msk64()) !== (exp64() & msk64())) begin
        bad++; $display("FAIL rnd64 k=%0d got=%h want=%h", k, obs64() & msk64(), exp64() & msk64());
      end
      total++;
      if ((obs32() & msk32()) !== (exp32() & msk32())) begin
        bad++; $display("FAIL rnd32 k=%0d got=%h want=%h", k, obs32() & msk32(), exp32() & msk32());
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    zero_out = 1'b0;
    reset    = 1'b1;
    flush    = 1'b0;
    b64.in_valid = 1'b0; b32.in_valid = 1'b0;
    b64.in_instr = '0;   b32.in_instr = '0;
    b64.in_pc    = '0;   b32.in_pc    = '0;
    b64.out_ready = 1'b0; b32.out_ready = 1'b0;
    test_reset();
    test_isb();
    test_uj();
    test_illegal_r();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
